peripheral_mpram_arbiter: RTL

Shares one single-port SRAM macro between NUM_PORTS requesters, each being an AXI4-to-SRAM adapter driving req/we/addr/be/data.
- Grant is combinational; rotation is round-robin.
- A requester may lock the port for a burst, with a bounded hold.
- Read data returns one cycle after grant, tagged per port.
- Sits between the per-master AXI4 SRAM adapters and the memory macro in the MPRAM peripheral.

---
 rtl/peripheral_mpram_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/peripheral_mpram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_PORTS requesters, with bounded burst locking.
// Define PERIPHERAL_MPRAM_ARBITER_STATS_EN to add the saturating conflict_cnt_o counter.
module peripheral_mpram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LOCK_MAX   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0]              lock_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
`ifdef PERIPHERAL_MPRAM_ARBITER_STATS_EN
  ,
  output logic [31:0]                       conflict_cnt_o
`endif
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW   = $clog2(LOCK_MAX + 1);
  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rpend_q, rpend_d;
  logic [PW-1:0]   ridx_q, ridx_d;

  logic            rr_found;
  logic [PW-1:0]   rr_idx;
  logic            gnt_vld;
  logic            do_arb;
  logic [PW-1:0]   gnt_idx;
  int              j;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (i == PW'(NUM_PORTS - 1)) return '0;
    return i + PW'(1);
  endfunction

  // First requester at or after the pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    j        = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      j = (int'(ptr_q) + off) % NUM_PORTS;
      if (!rr_found && req_i[j]) begin
        rr_found = 1'b1;
        rr_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    do_arb  = 1'b0;
    case (state_q)
      ARB: do_arb = 1'b1;
      LOCKED: begin
        // Hold budget exhausted: fall back to normal arbitration this same cycle.
        if (cnt_q >= CW'(LOCK_MAX)) begin
          state_d = ARB;
          do_arb  = 1'b1;
        end else if (req_i[owner_q]) begin
          gnt_vld = 1'b1;
          gnt_idx = owner_q;
          ptr_d   = next_idx(owner_q);
          if (lock_i[owner_q]) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase
    if (do_arb) begin
      cnt_d = '0;
      if (rr_found) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
        ptr_d   = next_idx(rr_idx);
        if (lock_i[rr_idx]) begin
          state_d = LOCKED;
          owner_d = rr_idx;
          cnt_d   = CW'(1);
        end
      end
    end
  end

  // Grant and memory mux are suppressed while reset is asserted.
  always_comb begin
    gnt_o       = '0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      gnt_o[k] = gnt_vld && rst_ni && (gnt_idx == PW'(k));
      if (gnt_o[k]) begin
        mem_we_o    = we_i[k];
        mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_be_o    = be_i[k*BE_W +: BE_W];
        mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_req_o = |gnt_o;
  assign rdata_o   = mem_rdata_i;

  always_comb begin
    rpend_d = mem_req_o & ~mem_we_o;
    ridx_d  = gnt_idx;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rvalid_o[k] = rpend_q && (ridx_q == PW'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      rpend_q <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rpend_q <= rpend_d;
      ridx_q  <= ridx_d;
    end
  end

`ifdef PERIPHERAL_MPRAM_ARBITER_STATS_EN
  logic [31:0]          conflict_q, conflict_d;
  logic [NUM_PORTS-1:0] owner_mask;
  logic                 conflict;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      owner_mask[k] = (owner_q == PW'(k));
    end
    conflict   = ($countones(req_i) >= 2) ||
                 ((state_q == LOCKED) && |(req_i & ~owner_mask));
    conflict_d = conflict ? sat_inc(conflict_q) : conflict_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_q <= '0;
    else         conflict_q <= conflict_d;
  end

  assign conflict_cnt_o = conflict_q;
`endif

endmodule
